// File: rtl/data_line_sequencer.sv
// data_line_sequencer
//   Command-side initiator for the data line (RAM plus data counter).
//   Takes Brainfuck-style data operations from the instruction decoder and
//   sequences the LOAD/STORE/INC/DEC strobes. It owns the data pointer.
//   The data counter acts as a one-cell write-back cache. A cell is loaded
//   only when first needed. It is written back only when dirty, and only when
//   the pointer moves or a flush is requested.
//
// Ports
//   CLOCK      system clock, rising edge
//   RST        asynchronous active-high reset
//   CMD_VALID  command present on CMD
//   CMD        0 NOP, 1 DATA_INC, 2 DATA_DEC, 3 PTR_INC, 4 PTR_DEC,
//              5 TEST, 6 FLUSH, 7 reserved (NOP)
//   CMD_READY  idle; a command is accepted when CMD_VALID && CMD_READY
//   DONE       one-cycle pulse in the final cycle of each command
//   ADDRESS    data pointer to RAM
//   LOAD       counter <= RAM[ADDRESS]
//   STORE      RAM[ADDRESS] <= counter
//   INC / DEC  counter increment / decrement strobes
//   DATA_IN    current data counter value
//   ZERO       registered result of the last TEST (DATA_IN == 0)
module data_line_sequencer #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned MAX_ADDRESS   = 29999,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                     CLOCK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  input  logic [2:0]               CMD,
  output logic                     CMD_READY,
  output logic                     DONE,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS,
  output logic                     LOAD,
  output logic                     STORE,
  output logic                     INC,
  output logic                     DEC,
  input  logic [DATA_WIDTH-1:0]    DATA_IN,
  output logic                     ZERO
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_WB, S_MOVE, S_SAMPLE, S_ACK
  } state_t;

  typedef enum logic [2:0] {
    C_NOP      = 3'd0,
    C_DATA_INC = 3'd1,
    C_DATA_DEC = 3'd2,
    C_PTR_INC  = 3'd3,
    C_PTR_DEC  = 3'd4,
    C_TEST     = 3'd5,
    C_FLUSH    = 3'd6,
    C_RSVD     = 3'd7
  } cmd_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX = ADDRESS_WIDTH'(MAX_ADDRESS);
  localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);

  state_t                     state;
  cmd_t                       cmd_q;
  logic                       cached;   // counter holds RAM[ADDRESS]
  logic                       dirty;    // counter differs from RAM[ADDRESS]
  logic                       zero_q;
  logic [ADDRESS_WIDTH-1:0]   address_q;

  always_ff @(posedge CLOCK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cmd_q     <= C_NOP;
      cached    <= 1'b0;
      dirty     <= 1'b0;
      zero_q    <= 1'b0;
      address_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            cmd_q <= cmd_t'(CMD);
            case (cmd_t'(CMD))
              C_DATA_INC, C_DATA_DEC: state <= cached ? S_EXEC : S_FETCH;
              C_PTR_INC, C_PTR_DEC:   state <= dirty ? S_WB : S_MOVE;
              C_TEST:                 state <= cached ? S_SAMPLE : S_FETCH;
              C_FLUSH:                state <= dirty ? S_WB : S_ACK;
              default:                state <= S_ACK;
            endcase
          end
        end
        S_FETCH: begin
          cached <= 1'b1;
          state  <= (cmd_q == C_TEST) ? S_SAMPLE : S_EXEC;
        end
        S_EXEC: begin
          dirty <= 1'b1;
          state <= S_IDLE;
        end
        S_WB: begin
          // FLUSH finishes in the write-back cycle; pointer moves continue to MOVE
          dirty <= 1'b0;
          state <= (cmd_q == C_FLUSH) ? S_IDLE : S_MOVE;
        end
        S_MOVE: begin
          cached <= 1'b0;
          state  <= S_IDLE;
          if (cmd_q == C_PTR_INC)
            address_q <= (address_q == ADDR_MAX) ? '0 : address_q + ADDR_ONE;
          else
            address_q <= (address_q == '0) ? ADDR_MAX : address_q - ADDR_ONE;
        end
        S_SAMPLE: begin
          zero_q <= (DATA_IN == '0);
          state  <= S_IDLE;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // All strobes are pure decodes of registered state, one cycle each
  assign CMD_READY = (state == S_IDLE);
  assign LOAD      = (state == S_FETCH);
  assign STORE     = (state == S_WB);
  assign INC       = (state == S_EXEC) && (cmd_q == C_DATA_INC);
  assign DEC       = (state == S_EXEC) && (cmd_q == C_DATA_DEC);
  assign DONE      = (state == S_EXEC) || (state == S_MOVE) ||
                     (state == S_SAMPLE) || (state == S_ACK) ||
                     ((state == S_WB) && (cmd_q == C_FLUSH));
  assign ADDRESS   = address_q;
  assign ZERO      = zero_q;

endmodule

// File: tb/tb_data_line_sequencer.sv
// Bench for data_line_sequencer: a RAM + counter environment reacts to the
// strobes. A cache-level reference model predicts each command's response
// (latency, strobe counts, store address, resulting pointer and ZERO) into a
// queue. A monitor reconstructs each observed command and compares it.
module tb_data_line_sequencer;
  localparam int unsigned AW   = 16;
  localparam int unsigned MAXA = 29999;
  localparam int unsigned DW   = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic          cmd_ready, done, load, store, inc, dec, zero;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;

  data_line_sequencer #(.ADDRESS_WIDTH(AW), .MAX_ADDRESS(MAXA), .DATA_WIDTH(DW)) dut (
    .CLOCK(clk), .RST(rst), .CMD_VALID(cmd_valid), .CMD(cmd),
    .CMD_READY(cmd_ready), .DONE(done), .ADDRESS(address),
    .LOAD(load), .STORE(store), .INC(inc), .DEC(dec),
    .DATA_IN(data_in), .ZERO(zero)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int errors   = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- environment: RAM and data counter ----------------
  logic [DW-1:0] ram [0:MAXA];
  logic [DW-1:0] ctr;
  assign data_in = ctr;

  always @(posedge clk) begin
    if (load && address <= MAXA) ctr <= ram[address];
    if (store && address <= MAXA) ram[address] = ctr;
    if (inc) ctr <= ctr + 8'd1;
    if (dec) ctr <= ctr - 8'd1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    int lat; int loads; int stores; int incs; int decs;
    int saddr; int addr; int zero;
  } txn_t;

  txn_t          expq[$];
  logic [DW-1:0] mem [0:MAXA];   // what RAM should hold
  logic [DW-1:0] cval;           // what the counter should hold
  bit            m_cached, m_dirty, m_zero;
  int unsigned   ptr;

  task automatic model_reset();
    ptr = 0; m_cached = 0; m_dirty = 0; m_zero = 0;
  endtask

  function automatic txn_t predict(input logic [2:0] c);
    txn_t t;
    t = '{default: 0};
    t.lat = 1;
    case (c)
      3'd1, 3'd2: begin
        if (!m_cached) begin t.lat = 2; t.loads = 1; cval = mem[ptr]; m_cached = 1; end
        if (c == 3'd1) begin t.incs = 1; cval = cval + 8'd1; end
        else           begin t.decs = 1; cval = cval - 8'd1; end
        m_dirty = 1;
      end
      3'd3, 3'd4: begin
        if (m_dirty) begin
          t.lat = 2; t.stores = 1; t.saddr = int'(ptr); mem[ptr] = cval; m_dirty = 0;
        end
        m_cached = 0;
        if (c == 3'd3) ptr = (ptr == MAXA) ? 0 : ptr + 1;
        else           ptr = (ptr == 0) ? MAXA : ptr - 1;
      end
      3'd5: begin
        if (!m_cached) begin t.lat = 2; t.loads = 1; cval = mem[ptr]; m_cached = 1; end
        m_zero = (cval == 8'd0);
      end
      3'd6: begin
        if (m_dirty) begin t.stores = 1; t.saddr = int'(ptr); mem[ptr] = cval; m_dirty = 0; end
      end
      default: ;
    endcase
    t.addr = int'(ptr);
    t.zero = int'(m_zero);
    return t;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  bit   busy = 0, pend = 0, ready_s = 0;
  int   cyc;
  txn_t cur, obs;

  always begin : mon
    txn_t e;
    @(posedge clk);
    if (!rst && cmd_valid && ready_s) begin
      busy = 1; cyc = 0; cur = '{default: 0};
    end
    @(negedge clk);
    if (rst) begin
      busy = 0; pend = 0;
    end else begin
      chk("strobe_exclusive", int'($countones({load, store, inc, dec}) <= 1), 1);
      chk("address_range", int'(address <= MAXA), 1);
      if (pend) begin
        pend = 0;
        obs.addr = int'(address);
        obs.zero = int'(zero);
        chk("txn_expected", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("latency", obs.lat, e.lat);
          chk("load_count", obs.loads, e.loads);
          chk("store_count", obs.stores, e.stores);
          chk("inc_count", obs.incs, e.incs);
          chk("dec_count", obs.decs, e.decs);
          if (e.stores != 0) chk("store_address", obs.saddr, e.saddr);
          chk("address_after", obs.addr, e.addr);
          chk("zero_after", obs.zero, e.zero);
        end
      end
      if (busy) begin
        cyc++;
        cur.loads  += int'(load);
        cur.stores += int'(store);
        cur.incs   += int'(inc);
        cur.decs   += int'(dec);
        if (store) cur.saddr = int'(address);
        if (done) begin
          cur.lat = cyc; obs = cur; busy = 0; pend = 1;
        end else if (cyc > 10) begin
          chk("done_within_budget", int'(cyc <= 10), 1);
          busy = 0;
        end
      end else begin
        chk("idle_no_strobe", int'({load, store, inc, dec, done} != 5'd0), 0);
      end
    end
    ready_s = cmd_ready;
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Call at negedge+1. junk: hold CMD_VALID high with random CMD while busy.
  task automatic issue(input logic [2:0] c, input bit junk, input bit push);
    int n = 0;
    while (!cmd_ready && n < 40) begin
      cmd_valid = junk; cmd = 3'($urandom);
      tick(); n++;
    end
    chk("ready_timeout", int'(cmd_ready), 1);
    if (junk && $urandom_range(0, 3) == 0) begin
      cmd_valid = 0; cmd = 3'($urandom); tick();
    end
    cmd_valid = 1; cmd = c;
    if (push) expq.push_back(predict(c));
    tick();
    cmd_valid = 0; cmd = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((expq.size() != 0 || busy || pend || !cmd_ready) && n < 60) begin
      tick(); n++;
    end
    chk("drain_queue_empty", int'(expq.size()), 0);
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    rst = 1;
    model_reset();
    expq.delete();
    tick(); tick();
    rst = 0;
    tick();
  endtask

  function automatic int pick_cmd();
    int r = $urandom_range(0, 15);
    if (r <= 3)  return 1;
    if (r <= 6)  return 2;
    if (r <= 8)  return 3;
    if (r <= 10) return 4;
    if (r <= 12) return 5;
    if (r == 13) return 6;
    if (r == 14) return 0;
    return 7;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int mism;
    logic [DW-1:0] v;
    rst = 1; cmd_valid = 0; cmd = 3'd0;
    for (int i = 0; i <= int'(MAXA); i++) begin
      v = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      ram[i] = v; mem[i] = v;
    end
    ram[0] = 8'd7; mem[0] = 8'd7;
    model_reset();
    tick(); tick();
    // reset state
    chk("reset_address", int'(address), 0);
    chk("reset_strobes", int'({load, store, inc, dec, done}), 0);
    chk("reset_zero", int'(zero), 0);
    chk("reset_ready", int'(cmd_ready), 1);
    rst = 0;
    tick();

    // three back-to-back increments from RAM[0]=7
    repeat (3) issue(3'd1, 0, 1);
    drain();
    chk("data_in_after_3inc", int'(data_in), 10);

    // pointer move writes back cell 0, next DATA_DEC loads cell 1
    issue(3'd3, 0, 1);
    issue(3'd2, 0, 1);
    drain();
    chk("ram0_written_back", int'(ram[0]), 10);

    // pointer wrap on a clean cache
    do_reset();
    issue(3'd4, 0, 1);
    drain();
    chk("wrap_down_address", int'(address), int'(MAXA));
    issue(3'd3, 0, 1);
    drain();
    chk("wrap_up_address", int'(address), 0);

    // TEST / FLUSH sequence on a zero cell
    ram[0] = 8'd0; mem[0] = 8'd0;
    issue(3'd5, 0, 1);
    drain();
    chk("test_zero_cell", int'(zero), 1);
    issue(3'd1, 0, 1);
    issue(3'd5, 0, 1);
    drain();
    chk("test_nonzero_cell", int'(zero), 0);
    issue(3'd6, 0, 1);
    issue(3'd6, 0, 1);
    drain();

    // busy-time CMD noise, reserved command
    issue(3'd2, 1, 1);
    issue(3'd7, 1, 1);
    issue(3'd1, 1, 1);
    issue(3'd0, 1, 1);
    drain();

    // reset during the write-back of a PTR_INC
    issue(3'd1, 0, 1);
    drain();
    cmd_valid = 1; cmd = 3'd3;
    tick();
    cmd_valid = 0;
    chk("wb_store_high", int'(store), 1);
    chk("wb_address_old_cell", int'(address), int'(ptr));
    rst = 1;
    #1;
    chk("abort_outputs", int'({load, store, inc, dec, done, zero}), 0);
    chk("abort_address", int'(address), 0);
    model_reset();
    expq.delete();
    tick(); tick();
    rst = 0;
    tick();
    chk("ready_after_abort", int'(cmd_ready), 1);
    issue(3'd1, 0, 1);
    drain();

    // randomized traffic, then flush and compare the whole RAM image
    repeat (300) issue(3'(pick_cmd()), 1, 1);
    issue(3'd6, 1, 1);
    drain();
    mism = 0;
    for (int i = 0; i <= int'(MAXA); i++)
      if (ram[i] !== mem[i]) mism++;
    chk("ram_image_mismatches", mism, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/data_line_sequencer.md
Name: data_line_sequencer

Overview:
- Command-side initiator for the data line (RAM plus data counter).
- Accepts Brainfuck-style data operations from the instruction decoder: cell +/-, pointer +/-, zero test, flush.
- Sequences the data line strobes LOAD, STORE, INC and DEC, and owns the data pointer.
- Write-back cache of one cell: the counter is loaded lazily and stored only when dirty and the pointer moves or a flush is requested.

Parameters:
ADDRESS_WIDTH  16  width of data pointer
MAX_ADDRESS  29999  highest valid cell address; pointer wraps at this bound
DATA_WIDTH  8  width of cell / counter value

Ports:
CLOCK  input  1  system clock; all state changes on rising edge
RST  input  1  asynchronous, active-high reset
CMD_VALID  input  1  command present on CMD
CMD  input  3  0 NOP, 1 DATA_INC, 2 DATA_DEC, 3 PTR_INC, 4 PTR_DEC, 5 TEST, 6 FLUSH, 7 reserved (treated as NOP)
CMD_READY  output  1  sequencer idle; command accepted on edge where CMD_VALID and CMD_READY are both high
DONE  output  1  one-cycle pulse in the final cycle of each accepted command
ADDRESS  output  ADDRESS_WIDTH  data pointer to RAM
LOAD  output  1  one-cycle strobe: counter <= RAM[ADDRESS]
STORE  output  1  one-cycle strobe: RAM[ADDRESS] <= counter
INC  output  1  one-cycle counter increment strobe
DEC  output  1  one-cycle counter decrement strobe
DATA_IN  input  DATA_WIDTH  current data counter value
ZERO  output  1  registered result of last TEST (DATA_IN == 0)

Behaviour:
- Reset (async, immediate): state IDLE; ADDRESS=0; LOAD, STORE, INC, DEC, DONE = 0; ZERO=0; internal flags CACHED=0, DIRTY=0.
- Reset mid-command aborts the command; unstored counter contents are discarded.
- CMD_READY = (state == IDLE), decoded from state only. CMD is sampled once at acceptance; CMD_VALID while not ready is ignored, with no queueing.
- States: IDLE, FETCH, EXEC, WB, MOVE, SAMPLE, ACK. All strobes are decoded from the current state, so each is high for exactly one cycle. LOAD, STORE, INC and DEC are never high together.
- Cycle 1 is the first cycle after acceptance.
- DATA_INC / DATA_DEC:
  - If !CACHED: FETCH (LOAD=1, CACHED<=1), then EXEC.
  - EXEC: INC or DEC = 1, DONE=1, DIRTY<=1, then IDLE.
  - Latency: 1 cycle when cached, 2 when not.
  - Counter wrap 255<->0 is the counter's concern; the sequencer does not check it.
- PTR_INC / PTR_DEC:
  - If DIRTY: WB (STORE=1, DIRTY<=0), then MOVE.
  - MOVE: DONE=1; ADDRESS updates at the end of the cycle; CACHED<=0; then IDLE.
  - Wrap: ADDRESS==MAX_ADDRESS with PTR_INC -> 0. ADDRESS==0 with PTR_DEC -> MAX_ADDRESS.
  - ADDRESS is held stable throughout WB, so the store targets the old cell.
- TEST:
  - If !CACHED: FETCH, then SAMPLE.
  - SAMPLE: ZERO <= (DATA_IN == 0); DONE=1. DIRTY is unchanged.
  - ZERO changes only in SAMPLE and at reset.
- FLUSH:
  - If DIRTY: WB with DONE=1 in the same cycle, DIRTY<=0, then IDLE.
  - Otherwise: ACK (DONE=1). CACHED is unchanged.
- NOP / reserved: ACK (DONE=1) only; no strobes.
- Back-to-back: the next command may be accepted in the cycle after DONE, since state is IDLE there.
- ADDRESS never exceeds MAX_ADDRESS. Bench assertion: any value > MAX_ADDRESS is an error.

Test Plan:
- Reset, then DATA_INC x3 back-to-back with DATA_IN modelled by a counter from RAM[0]=7 -> LOAD once; INC pulses in 3 commands; latencies 2,1,1; DATA_IN=10; STORE never asserted.
- After the above, PTR_INC -> STORE=1 with ADDRESS=0, then ADDRESS=1, DONE; next DATA_DEC asserts LOAD at ADDRESS=1 before DEC.
- Pointer wrap: reset, PTR_DEC -> ADDRESS=29999, no STORE (clean). PTR_INC -> ADDRESS=0.
- TEST on cell holding 0 -> LOAD, ZERO=1. DATA_INC then TEST -> no LOAD, ZERO=0 after SAMPLE. FLUSH -> STORE=1, DONE same cycle. Second FLUSH -> no STORE, DONE after 1 cycle.
- CMD_VALID held high with changing CMD during a busy command -> only the command present at the accepting edge executes; CMD=7 -> DONE only, no strobes.
- Assert RST during WB of a PTR_INC -> all outputs 0 immediately, ADDRESS=0, CMD_READY=1 after release; subsequent DATA_INC performs LOAD (cache invalidated).
